ascon_cmd_ctrl: RTL and testbench

Command sequencer between a 32-bit instruction/data stream (host, DMA or bench) and ascon_core. It decodes instruction headers and routes the data words that follow to the core's key or bdi handshake. It generates bdi_type, bdi_eot, bdi_eoi and valid-byte masks from the instruction's byte count, and buffers core output (bdo) into a 2-entry FIFO. It also captures tag-verification results and flags protocol errors and stalls.

---
 rtl/ascon_cmd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ascon_cmd_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_cmd_ctrl.sv
// Command sequencer for ascon_core: decodes 32-bit instruction headers, routes the
// following data words to the core's key/bdi ports and buffers core output in a 2-entry FIFO.
module ascon_cmd_ctrl #(
    parameter int CCW        = 32,
    parameter int CCSW       = 32,
    parameter int WDT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [CCSW-1:0] key,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CCW-1:0]  bdi,
    output logic            bdi_valid,
    input  logic            bdi_ready,
    output logic [3:0]      bdi_type,
    output logic            bdi_eot,
    output logic            bdi_eoi,
    output logic [3:0]      bdi_valid_bytes,
    output logic            decrypt,
    output logic            hash,
    input  logic [CCW-1:0]  bdo,
    input  logic            bdo_valid,
    output logic            bdo_ready,
    input  logic [3:0]      bdo_type,
    input  logic            bdo_eot,
    input  logic            auth,
    input  logic            auth_valid,
    output logic            auth_ready,
    output logic [31:0]     out_data,
    output logic [3:0]      out_type,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            auth_done,
    output logic            auth_ok,
    output logic            err,
    output logic            busy
);

    localparam logic [3:0] OP_DO_ENC   = 4'h0;
    localparam logic [3:0] OP_DO_DEC   = 4'h1;
    localparam logic [3:0] OP_DO_HASH  = 4'h2;
    localparam logic [3:0] OP_LD_KEY   = 4'h3;
    localparam logic [3:0] OP_LD_NONCE = 4'h4;
    localparam logic [3:0] OP_LD_AD    = 4'h5;
    localparam logic [3:0] OP_LD_PT    = 4'h6;
    localparam logic [3:0] OP_LD_CT    = 4'h7;
    localparam logic [3:0] OP_LD_TAG   = 4'h8;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'hC;
    localparam logic [3:0] D_AD    = 4'h1;
    localparam logic [3:0] D_PTCT  = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h8;

    localparam int              WDT_W    = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam int              ENT_W    = CCW + 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DATA      = 2'd1,
        S_WAIT_AUTH = 2'd2
    } state_t;

    function automatic logic [23:0] sat_sub4(input logic [23:0] c);
        return (c > 24'd4) ? (c - 24'd4) : 24'd0;
    endfunction

    function automatic logic [3:0] last_mask(input logic [23:0] c);
        return {c >= 24'd4, c >= 24'd3, c >= 24'd2, 1'b1};
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              eoi_q, eoi_d;
    logic [23:0]       cnt_q, cnt_d;
    logic              decrypt_q, decrypt_d;
    logic              hash_q, hash_d;
    logic              err_q, err_d;
    logic              auth_done_q, auth_done_d;
    logic              auth_ok_q, auth_ok_d;
    logic [WDT_W-1:0]  wdt_q, wdt_d;

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]  mem_q [2];

    logic in_idle, in_data, in_wait, is_key, last_beat;
    logic cmd_hs, auth_hs, push, pop, full;
    logic [3:0] hdr_op;
    logic [ENT_W-1:0] head;

    assign in_idle   = (state_q == S_IDLE);
    assign in_data   = (state_q == S_DATA);
    assign in_wait   = (state_q == S_WAIT_AUTH);
    assign is_key    = (op_q == OP_LD_KEY);
    assign last_beat = (cnt_q <= 24'd4);
    assign hdr_op    = cmd_data[31:28];

    // Core-facing handshake signals; ready outputs are held low while reset is asserted.
    always_comb begin
        cmd_ready       = 1'b0;
        key             = '0;
        key_valid       = 1'b0;
        bdi             = '0;
        bdi_valid       = 1'b0;
        bdi_type        = D_NULL;
        bdi_eot         = 1'b0;
        bdi_eoi         = 1'b0;
        bdi_valid_bytes = 4'h0;
        auth_ready      = rst_n & in_wait;
        if (in_idle) begin
            cmd_ready = rst_n;
        end else if (in_data) begin
            cmd_ready = is_key ? key_ready : bdi_ready;
            if (is_key) begin
                key       = cmd_data;
                key_valid = cmd_valid;
            end else begin
                bdi             = cmd_data;
                bdi_valid       = cmd_valid;
                bdi_eot         = last_beat;
                bdi_eoi         = last_beat & eoi_q;
                bdi_valid_bytes = last_beat ? last_mask(cnt_q) : 4'hF;
                case (op_q)
                    OP_LD_NONCE:         bdi_type = D_NONCE;
                    OP_LD_AD:            bdi_type = D_AD;
                    OP_LD_PT, OP_LD_CT:  bdi_type = D_PTCT;
                    OP_LD_TAG:           bdi_type = D_TAG;
                    default:             bdi_type = D_NULL;
                endcase
            end
        end
    end

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign auth_hs = auth_valid & auth_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        eoi_d       = eoi_q;
        cnt_d       = cnt_q;
        decrypt_d   = decrypt_q;
        hash_d      = hash_q;
        err_d       = err_q;
        auth_done_d = auth_done_q;
        auth_ok_d   = auth_ok_q;
        wdt_d       = wdt_q;
        case (state_q)
            S_IDLE: begin
                wdt_d = '0;
                if (cmd_hs) begin
                    case (hdr_op)
                        OP_DO_ENC, OP_DO_DEC, OP_DO_HASH: begin
                            decrypt_d   = (hdr_op == OP_DO_DEC);
                            hash_d      = (hdr_op == OP_DO_HASH);
                            err_d       = 1'b0;
                            auth_done_d = 1'b0;
                            auth_ok_d   = 1'b0;
                        end
                        OP_LD_KEY, OP_LD_NONCE, OP_LD_AD,
                        OP_LD_PT, OP_LD_CT, OP_LD_TAG: begin
                            op_d  = hdr_op;
                            eoi_d = cmd_data[24];
                            cnt_d = cmd_data[23:0];
                            if (cmd_data[23:0] != 24'd0) begin
                                state_d = S_DATA;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_DATA: begin
                if (cmd_hs) begin
                    wdt_d = '0;
                    cnt_d = sat_sub4(cnt_q);
                    if (last_beat) begin
                        state_d = (is_key || op_q != OP_LD_TAG || !decrypt_q) ? S_IDLE : S_WAIT_AUTH;
                    end
                end else if (wdt_q == WDT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end
            S_WAIT_AUTH: begin
                if (auth_hs) begin
                    wdt_d       = '0;
                    auth_done_d = 1'b1;
                    auth_ok_d   = auth;
                    state_d     = S_IDLE;
                end else if (wdt_q == WDT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output FIFO: two registered entries, runs regardless of the sequencer state.
    assign full      = (count_q == 2'd2);
    assign bdo_ready = rst_n & ~full;
    assign out_valid = (count_q != 2'd0);
    assign push      = bdo_valid & bdo_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head[ENT_W-1:5] : '0;
    assign out_type  = out_valid ? head[4:1] : 4'h0;
    assign out_last  = out_valid & head[0];

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bdo, bdo_type, bdo_eot};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'h0;
            eoi_q       <= 1'b0;
            cnt_q       <= '0;
            decrypt_q   <= 1'b0;
            hash_q      <= 1'b0;
            err_q       <= 1'b0;
            auth_done_q <= 1'b0;
            auth_ok_q   <= 1'b0;
            wdt_q       <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            eoi_q       <= eoi_d;
            cnt_q       <= cnt_d;
            decrypt_q   <= decrypt_d;
            hash_q      <= hash_d;
            err_q       <= err_d;
            auth_done_q <= auth_done_d;
            auth_ok_q   <= auth_ok_d;
            wdt_q       <= wdt_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign decrypt   = decrypt_q;
    assign hash      = hash_q;
    assign err       = err_q;
    assign auth_done = auth_done_q;
    assign auth_ok   = auth_ok_q;
    assign busy      = ~in_idle;

endmodule

// File: tb/tb_ascon_cmd_ctrl.sv
// Directed bench for ascon_cmd_ctrl: header decode, key/bdi routing, masks, FIFO,
// tag verification, error, watchdog and asynchronous reset.
module tb_ascon_cmd_ctrl;

    localparam int WDT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd_data;
    logic        cmd_valid, cmd_ready;
    logic [31:0] key;
    logic        key_valid, key_ready;
    logic [31:0] bdi;
    logic        bdi_valid, bdi_ready;
    logic [3:0]  bdi_type;
    logic        bdi_eot, bdi_eoi;
    logic [3:0]  bdi_valid_bytes;
    logic        decrypt, hash;
    logic [31:0] bdo;
    logic        bdo_valid, bdo_ready;
    logic [3:0]  bdo_type;
    logic        bdo_eot;
    logic        auth, auth_valid, auth_ready;
    logic [31:0] out_data;
    logic [3:0]  out_type;
    logic        out_last, out_valid, out_ready;
    logic        auth_done, auth_ok, err, busy;

    int n_vec  = 0;
    int n_miss = 0;

    ascon_cmd_ctrl #(.CCW(32), .CCSW(32), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
        .bdi_valid_bytes(bdi_valid_bytes), .decrypt(decrypt), .hash(hash),
        .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
        .bdo_type(bdo_type), .bdo_eot(bdo_eot),
        .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready),
        .out_data(out_data), .out_type(out_type), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .auth_done(auth_done), .auth_ok(auth_ok), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cmd_data = '0; cmd_valid = 1'b0; key_ready = 1'b0; bdi_ready = 1'b0;
        bdo = '0; bdo_valid = 1'b0; bdo_type = 4'h0; bdo_eot = 1'b0;
        auth = 1'b0; auth_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_bdo_ready", bdo_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_bdi_type", bdi_type, 4'h0);
        chk("rst_out_valid", out_valid, 0);
        nxt(); rst_n = 1'b1; #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_bdo_ready", bdo_ready, 1);

        // Mode headers, then a 16-byte key load
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h2000_0000; #1;
        nxt(); cmd_data = 32'h0000_0000; #1;
        chk("hash_mode", hash, 1);
        chk("hash_decrypt", decrypt, 0);
        nxt(); cmd_data = 32'h3000_0010; key_ready = 1'b1; #1;
        chk("enc_hash", hash, 0);
        chk("enc_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            nxt(); cmd_data = 32'hC0DE_0000 + i; #1;
            chk("key_busy", busy, 1);
            chk("key_valid", key_valid, 1);
            chk("key_word", key, 32'hC0DE_0000 + i);
            chk("key_cmd_ready", cmd_ready, 1);
            chk("key_bdi_valid", bdi_valid, 0);
        end
        nxt(); cmd_valid = 1'b0; key_ready = 1'b0; #1;
        chk("key_done_busy", busy, 0);

        // AD, 6 bytes, end of input
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h5100_0006; bdi_ready = 1'b1; #1;
        nxt(); cmd_data = 32'hAAAA_0001; #1;
        chk("ad1_word", bdi, 32'hAAAA_0001);
        chk("ad1_type", bdi_type, 4'h1);
        chk("ad1_mask", bdi_valid_bytes, 4'hF);
        chk("ad1_eot", bdi_eot, 0);
        nxt(); cmd_data = 32'hBBBB_0002; #1;
        chk("ad2_word", bdi, 32'hBBBB_0002);
        chk("ad2_mask", bdi_valid_bytes, 4'b0011);
        chk("ad2_eot", bdi_eot, 1);
        chk("ad2_eoi", bdi_eoi, 1);
        chk("ad2_type", bdi_type, 4'h1);
        nxt(); cmd_valid = 1'b0; #1;
        chk("ad_done_busy", busy, 0);
        chk("ad_done_type", bdi_type, 4'h0);

        // Nonce, 5 bytes, not end of input
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h4000_0005; #1;
        nxt(); cmd_data = 32'h1111_0000; #1;
        chk("n1_type", bdi_type, 4'hC);
        chk("n1_mask", bdi_valid_bytes, 4'hF);
        nxt(); cmd_data = 32'h1111_0001; #1;
        chk("n2_mask", bdi_valid_bytes, 4'b0001);
        chk("n2_eot", bdi_eot, 1);
        chk("n2_eoi", bdi_eoi, 0);
        nxt(); cmd_valid = 1'b0; #1;
        chk("n_done_busy", busy, 0);

        // PT, 8 bytes, bdi_ready toggling
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h6100_0008; #1;
        nxt(); cmd_data = 32'h5050_0000; bdi_ready = 1'b0; #1;
        chk("pt_stall_ready", cmd_ready, 0);
        chk("pt_stall_valid", bdi_valid, 1);
        nxt(); bdi_ready = 1'b1; #1;
        chk("pt1_ready", cmd_ready, 1);
        chk("pt1_word", bdi, 32'h5050_0000);
        chk("pt1_eot", bdi_eot, 0);
        chk("pt1_type", bdi_type, 4'h4);
        nxt(); cmd_data = 32'h5050_0001; bdi_ready = 1'b0; #1;
        chk("pt2_stall_ready", cmd_ready, 0);
        chk("pt2_busy", busy, 1);
        chk("pt2_word", bdi, 32'h5050_0001);
        nxt(); bdi_ready = 1'b1; #1;
        chk("pt2_ready", cmd_ready, 1);
        chk("pt2_eot", bdi_eot, 1);
        chk("pt2_eoi", bdi_eoi, 1);
        chk("pt2_mask", bdi_valid_bytes, 4'hF);
        nxt(); cmd_valid = 1'b0; #1;
        chk("pt_done_busy", busy, 0);

        // Output FIFO: 4 words with the consumer stalled for 5 cycles
        nxt(); bdo_valid = 1'b1; bdo = 32'hD000_0000; bdo_type = 4'h4; bdo_eot = 1'b0; #1;
        chk("f_empty", out_valid, 0);
        nxt(); bdo = 32'hD000_0001; #1;
        chk("f_lat_valid", out_valid, 1);
        chk("f_lat_data", out_data, 32'hD000_0000);
        nxt(); bdo = 32'hD000_0002; #1;
        chk("f_full", bdo_ready, 0);
        repeat (2) nxt();
        nxt(); out_ready = 1'b1; #1;
        chk("f_still_full", bdo_ready, 0);
        chk("f_head0", out_data, 32'hD000_0000);
        nxt(); #1;
        chk("f_head1", out_data, 32'hD000_0001);
        chk("f_type1", out_type, 4'h4);
        chk("f_last1", out_last, 0);
        chk("f_room", bdo_ready, 1);
        nxt(); bdo = 32'hD000_0003; bdo_type = 4'h8; bdo_eot = 1'b1; #1;
        chk("f_head2", out_data, 32'hD000_0002);
        nxt(); bdo_valid = 1'b0; #1;
        chk("f_head3", out_data, 32'hD000_0003);
        chk("f_type3", out_type, 4'h8);
        chk("f_last3", out_last, 1);
        nxt(); out_ready = 1'b0; bdo_type = 4'h0; bdo_eot = 1'b0; #1;
        chk("f_drained", out_valid, 0);

        // Decrypt, tag load, failed verification
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h1000_0000; #1;
        nxt(); cmd_data = 32'h8100_0010; bdi_ready = 1'b1; #1;
        chk("dec_mode", decrypt, 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); cmd_data = 32'h7A90_0000 + i; #1;
            chk("tag_type", bdi_type, 4'h8);
        end
        nxt(); cmd_valid = 1'b0; #1;
        chk("wait_busy", busy, 1);
        chk("wait_auth_ready", auth_ready, 1);
        chk("wait_cmd_ready", cmd_ready, 0);
        nxt();
        nxt(); auth_valid = 1'b1; auth = 1'b0; #1;
        chk("wait_done_pre", auth_done, 0);
        nxt(); auth_valid = 1'b0; #1;
        chk("auth_done", auth_done, 1);
        chk("auth_ok0", auth_ok, 0);
        chk("auth_busy", busy, 0);
        chk("auth_ready_off", auth_ready, 0);
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h0000_0000; #1;
        nxt(); cmd_valid = 1'b0; #1;
        chk("enc_clr_done", auth_done, 0);
        chk("enc_clr_dec", decrypt, 0);

        // Decrypt, short tag, successful verification
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h1000_0000; #1;
        nxt(); cmd_data = 32'h8100_0004; #1;
        nxt(); cmd_data = 32'h7A90_00FF; #1;
        chk("tag4_mask", bdi_valid_bytes, 4'hF);
        nxt(); cmd_valid = 1'b0; auth_valid = 1'b1; auth = 1'b1; #1;
        chk("tag4_auth_ready", auth_ready, 1);
        nxt(); auth_valid = 1'b0; auth = 1'b0; #1;
        chk("auth_done1", auth_done, 1);
        chk("auth_ok1", auth_ok, 1);

        // Unknown opcode, then clear
        nxt(); cmd_valid = 1'b1; cmd_data = 32'hF000_0000; #1;
        nxt(); cmd_valid = 1'b0; #1;
        chk("bad_op_err", err, 1);
        chk("bad_op_busy", busy, 0);
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h0000_0000; #1;
        nxt(); cmd_valid = 1'b0; #1;
        chk("err_cleared", err, 0);

        // Zero-length load issues no beat
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h5000_0000; #1;
        nxt(); cmd_valid = 1'b0; #1;
        chk("zero_busy", busy, 0);

        // Watchdog: header accepted, then bdi_ready held low
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h5100_0004; bdi_ready = 1'b0; #1;
        nxt(); cmd_valid = 1'b0; #1;
        chk("wdt_start_busy", busy, 1);
        repeat (WDT - 1) nxt();
        #1;
        chk("wdt_pre_busy", busy, 1);
        chk("wdt_pre_err", err, 0);
        nxt(); #1;
        chk("wdt_err", err, 1);
        chk("wdt_busy", busy, 0);

        // Asynchronous reset mid-DATA with an entry in the FIFO
        nxt(); cmd_valid = 1'b1; cmd_data = 32'h1000_0000; #1;
        nxt(); cmd_data = 32'h6000_0008; bdo_valid = 1'b1; bdo = 32'hE000_0000; #1;
        nxt(); cmd_data = 32'h5050_00AA; bdi_ready = 1'b1; bdo_valid = 1'b0; #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_dec", decrypt, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_bdi_valid", bdi_valid, 0);
        chk("mid_rst_bdi", bdi, 0);
        chk("mid_rst_mask", bdi_valid_bytes, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_bdo_ready", bdo_ready, 0);
        chk("mid_rst_dec", decrypt, 0);
        nxt(); rst_n = 1'b1; cmd_valid = 1'b0; bdi_ready = 1'b0; #1;
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
